// File: rtl/rst_seq.sv
// Reset sequencer: holds every downstream domain in reset, then releases them one at a time
// in index order, waiting for each domain's acknowledge before releasing the next. A domain
// that never acknowledges, or drops its acknowledge once everything is up, latches a fault.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset (inverted output of the async reset synchronizer)
//   sw_rst_req_i   software reset request, single-cycle pulse; restarts the whole sequence
//   stage_ack_i    per-stage ready/init-done, synchronous to clk_i
//   stage_rst_o    per-stage active-high reset, registered
//   all_ready_o    every stage released and acknowledged
//   busy_o         sequence in progress (holding or releasing)
//   err_o          sticky acknowledge fault
//   err_stage_o    index of the faulting stage
module rst_seq #(
    parameter int unsigned N_STAGES       = 4,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        sw_rst_req_i,
    input  logic [N_STAGES-1:0]         stage_ack_i,
    output logic [N_STAGES-1:0]         stage_rst_o,
    output logic                        all_ready_o,
    output logic                        busy_o,
    output logic                        err_o,
    output logic [$clog2(N_STAGES)-1:0] err_stage_o
);

    localparam int unsigned KW     = $clog2(N_STAGES);
    localparam int unsigned MaxCnt = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES
                                                                     : TIMEOUT_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    typedef enum logic [1:0] {
        StHold,
        StRelease,
        StDone,
        StFault
    } state_e;

    state_e              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [N_STAGES-1:0] stage_rst_q, stage_rst_d;
    logic                all_ready_q, all_ready_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic [KW-1:0]       err_stage_q, err_stage_d;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        stage_rst_d = stage_rst_q;
        all_ready_d = all_ready_q;
        busy_d      = busy_q;
        err_d       = err_q;
        err_stage_d = err_stage_q;

        if (sw_rst_req_i) begin
            state_d     = StHold;
            k_d         = '0;
            cnt_d       = '0;
            stage_rst_d = '1;
            all_ready_d = 1'b0;
            busy_d      = 1'b1;
            err_d       = 1'b0;
            err_stage_d = '0;
        end else begin
            unique case (state_q)
                StHold: begin
                    // Counter was zeroed on the entry edge, so HOLD_CYCLES-1 marks the last cycle.
                    if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
                        state_d        = StRelease;
                        k_d            = '0;
                        cnt_d          = '0;
                        stage_rst_d[0] = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StRelease: begin
                    // Only the stage currently being released matters; lower stages dropping
                    // their ack here and unreleased stages are ignored.
                    if (stage_ack_i[k_q]) begin
                        cnt_d = '0;
                        if (k_q == KW'(N_STAGES - 1)) begin
                            state_d     = StDone;
                            all_ready_d = 1'b1;
                            busy_d      = 1'b0;
                        end else begin
                            k_d                       = k_q + KW'(1);
                            stage_rst_d[k_q + KW'(1)] = 1'b0;
                        end
                    end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        state_d     = StFault;
                        busy_d      = 1'b0;
                        err_d       = 1'b1;
                        err_stage_d = k_q;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    if (stage_ack_i != '1) begin
                        state_d     = StFault;
                        all_ready_d = 1'b0;
                        err_d       = 1'b1;
                        // Descending scan so the lowest dropped index wins.
                        for (int i = int'(N_STAGES) - 1; i >= 0; i--) begin
                            if (!stage_ack_i[i]) begin
                                err_stage_d = KW'(i);
                            end
                        end
                    end
                end
                StFault: begin
                    // Sticky: only sw_rst_req_i or rst_i leave this state.
                end
                default: begin
                    state_d = StFault;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StHold;
            k_q         <= '0;
            cnt_q       <= '0;
            stage_rst_q <= '1;
            all_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
            err_stage_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            stage_rst_q <= stage_rst_d;
            all_ready_q <= all_ready_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            err_stage_q <= err_stage_d;
        end
    end

    assign stage_rst_o = stage_rst_q;
    assign all_ready_o = all_ready_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;
    assign err_stage_o = err_stage_q;

endmodule

// File: tb/tb_rst_seq.sv
module tb_rst_seq;

    localparam int N = 4;
    localparam int H = 4;
    localparam int T = 8;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         sw_rst_req_i;
    logic [N-1:0] stage_ack_i;
    logic [N-1:0] stage_rst_o;
    logic         all_ready_o;
    logic         busy_o;
    logic         err_o;
    logic [1:0]   err_stage_o;

    rst_seq #(
        .N_STAGES      (N),
        .HOLD_CYCLES   (H),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .sw_rst_req_i(sw_rst_req_i),
        .stage_ack_i (stage_ack_i),
        .stage_rst_o (stage_rst_o),
        .all_ready_o (all_ready_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .err_stage_o (err_stage_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: how many stages are out of reset, how long we have been holding or
    // waiting, and whether the sequence completed or failed.
    int m_rel   = 0;
    int m_hold  = 0;
    int m_wait  = 0;
    bit m_ready = 0;
    bit m_err   = 0;
    int m_es    = 0;

    // Stimulus configuration.
    bit           auto_en  = 0;  // ack each stage a fixed delay after its release
    bit           rand_en  = 0;
    int           delay    = 2;
    logic [N-1:0] ack_mask = '1;
    int           age[N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic sw, input logic [N-1:0] ack);
        if (r || sw) begin
            m_rel = 0; m_hold = 0; m_wait = 0; m_ready = 0; m_err = 0; m_es = 0;
        end else if (m_err) begin
            // fault is sticky
        end else if (m_ready) begin
            if (ack != '1) begin
                m_err   = 1;
                m_ready = 0;
                m_es    = -1;
                for (int j = 0; j < N; j++) if (!ack[j] && m_es < 0) m_es = j;
            end
        end else if (m_rel == 0) begin
            m_hold++;
            if (m_hold == H) begin
                m_rel  = 1;
                m_wait = 0;
            end
        end else if (ack[m_rel-1]) begin
            if (m_rel == N) m_ready = 1;
            else m_rel++;
            m_wait = 0;
        end else begin
            m_wait++;
            if (m_wait == T) begin
                m_err = 1;
                m_es  = m_rel - 1;
            end
        end
    endtask

    task automatic compare();
        logic [N-1:0] e;
        e = '1;
        e = e << m_rel;
        check("stage_rst", 32'(stage_rst_o), 32'(e));
        check("all_ready", 32'(all_ready_o), 32'(m_ready));
        check("busy", 32'(busy_o), 32'(!m_err && !m_ready));
        check("err", 32'(err_o), 32'(m_err));
        check("err_stage", 32'(err_stage_o), 32'(m_es));
    endtask

    task automatic set_inputs();
        logic [N-1:0] a;
        if (rand_en) begin
            for (int j = 0; j < N; j++) a[j] = ($urandom_range(3) != 0);
            stage_ack_i = a;
        end else begin
            for (int j = 0; j < N; j++) a[j] = auto_en ? (age[j] >= delay) : 1'b1;
            stage_ack_i = a & ack_mask;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(rst_i, sw_rst_req_i, stage_ack_i);
        for (int j = 0; j < N; j++) age[j] = (j < m_rel) ? age[j] + 1 : -1;
        #1;
        compare();
        set_inputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int j = 0; j < N; j++) age[j] = -1;
        rst_i        = 1'b1;
        sw_rst_req_i = 1'b0;
        stage_ack_i  = '0;

        // Nominal bring-up, each ack two cycles after its release.
        run(2);
        rst_i   = 1'b0;
        auto_en = 1;
        set_inputs();
        run(25);
        check("nominal_ready", 32'(all_ready_o), 32'd1);
        check("nominal_rst", 32'(stage_rst_o), 32'd0);

        // Two acks drop together while up.
        ack_mask = 4'b0101;
        set_inputs();
        tick();
        check("loss_err_stage", 32'(err_stage_o), 32'd1);
        check("loss_ready", 32'(all_ready_o), 32'd0);
        run(3);

        // Software restart from fault, then again mid-release at k=1.
        ack_mask     = '1;
        sw_rst_req_i = 1'b1;
        set_inputs();
        tick();
        sw_rst_req_i = 1'b0;
        check("sw_fault_rst", 32'(stage_rst_o), 32'hF);
        check("sw_fault_err", 32'(err_o), 32'd0);
        run(8);
        check("mid_k1", 32'(stage_rst_o), 32'hC);
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        check("sw_mid_rst", 32'(stage_rst_o), 32'hF);
        check("sw_mid_busy", 32'(busy_o), 32'd1);

        // Stage 2 never acknowledges.
        ack_mask = 4'b1011;
        set_inputs();
        run(25);
        check("tmo_err", 32'(err_o), 32'd1);
        check("tmo_stage", 32'(err_stage_o), 32'd2);
        check("tmo_rst", 32'(stage_rst_o), 32'h8);

        // rst and sw_rst_req together mid-release.
        ack_mask     = '1;
        sw_rst_req_i = 1'b1;
        set_inputs();
        tick();
        sw_rst_req_i = 1'b0;
        run(8);
        rst_i        = 1'b1;
        sw_rst_req_i = 1'b1;
        tick();
        rst_i        = 1'b0;
        sw_rst_req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("prio_hold", 32'(stage_rst_o), 32'hF);
        end
        tick();
        check("prio_release", 32'(stage_rst_o), 32'hE);
        run(20);

        // Acks high from reset: one release per cycle.
        auto_en = 0;
        rst_i   = 1'b1;
        set_inputs();
        tick();
        rst_i = 1'b0;
        run(8);
        check("early_ready", 32'(all_ready_o), 32'd1);

        // Random traffic with occasional restarts.
        rand_en = 1;
        for (int i = 0; i < 400; i++) begin
            rst_i        = ($urandom_range(79) == 0);
            sw_rst_req_i = ($urandom_range(39) == 0);
            tick();
            rst_i        = 1'b0;
            sw_rst_req_i = 1'b0;
            if ($urandom_range(3) == 0) begin
                // Stretches with all acks high so sequences can complete.
                rand_en = 0;
                set_inputs();
                run($urandom_range(10, 3));
                rand_en = 1;
                set_inputs();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
